// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt controller for the five-stage MIPS pipeline: gates the PC, drains on HALT, counts fetch cycles.
// Optional run-cycle limit is compiled in with `define RUN_CTRL_CYCLE_LIMIT_EN.
module pipeline_run_ctrl #(
    parameter int         ADDR_BITS      = 32,
    parameter int         DATA_WIDTH     = 32,
    parameter int         CYCLE_CNT_BITS = 32,
    parameter int         DRAIN_CYCLES   = 4,
    parameter logic [5:0] HALT_OPCODE    = 6'b111111,
    parameter int         MAX_RUN_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    input  logic [1:0]                cmd_code,
    output logic                      cmd_ready,
    input  logic [DATA_WIDTH-1:0]     pc_instr_in,
    input  logic [ADDR_BITS-1:0]      pc_addr_in,
    output logic                      pc_enable_out,
    output logic                      pc_reset_out,
    output logic [2:0]                state_out,
    output logic [CYCLE_CNT_BITS-1:0] cycle_count_out,
    output logic [ADDR_BITS-1:0]      halt_pc_out,
    output logic                      halted_out,
    output logic                      done_pulse,
    output logic                      timeout_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4,
        S_PRST   = 3'd5
    } state_t;

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_HALT  = 2'b10;
    localparam logic [1:0] CMD_RESET = 2'b11;

    // One timer serves both the drain wait and the two-cycle pipeline reset.
    localparam int                TMR_BITS   = $clog2(DRAIN_CYCLES + 2);
    localparam logic [TMR_BITS-1:0] DRAIN_LOAD = TMR_BITS'(DRAIN_CYCLES - 1);
    localparam logic [TMR_BITS-1:0] PRST_LOAD  = TMR_BITS'(1);

    state_t                      state_reg;
    logic [TMR_BITS-1:0]         timer_reg;
    logic [CYCLE_CNT_BITS-1:0]   cycle_count_reg;
    logic [ADDR_BITS-1:0]        halt_pc_reg;
    logic                        done_reg;
    logic                        timeout_reg;

    logic halt_det;
    logic cmd_accept;
    logic stop_cmd;
    logic limit_hit;
    logic unused_bits;

    assign halt_det    = (pc_instr_in[DATA_WIDTH-1 -: 6] == HALT_OPCODE);
    assign unused_bits = ^pc_instr_in[DATA_WIDTH-7:0];

    assign cmd_ready  = (state_reg == S_IDLE) || (state_reg == S_RUN) || (state_reg == S_HALTED);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign stop_cmd   = cmd_accept && ((cmd_code == CMD_HALT) || (cmd_code == CMD_RESET));

`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    localparam logic [CYCLE_CNT_BITS-1:0] RUN_LIMIT = CYCLE_CNT_BITS'(MAX_RUN_CYCLES);
    assign limit_hit = (state_reg == S_RUN) && (cycle_count_reg >= RUN_LIMIT);
`else
    logic unused_limit;
    assign unused_limit = (MAX_RUN_CYCLES > 0);
    assign limit_hit    = 1'b0;
`endif

    // Fetch must stop in the very cycle the stop condition is seen, so the enable is combinational.
    always_comb begin
        pc_enable_out = 1'b0;
        case (state_reg)
            S_RUN:   pc_enable_out = !halt_det && !stop_cmd && !limit_hit;
            S_STEP:  pc_enable_out = !halt_det;
            default: pc_enable_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            timer_reg       <= '0;
            cycle_count_reg <= '0;
            halt_pc_reg     <= '0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (pc_enable_out && (cycle_count_reg != '1)) begin
                cycle_count_reg <= cycle_count_reg + 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (cmd_accept) begin
                        case (cmd_code)
                            CMD_RUN:  state_reg <= S_RUN;
                            CMD_STEP: state_reg <= S_STEP;
                            CMD_HALT: begin
                                state_reg <= S_DRAIN;
                                timer_reg <= DRAIN_LOAD;
                            end
                            default: begin
                                state_reg       <= S_PRST;
                                timer_reg       <= PRST_LOAD;
                                cycle_count_reg <= '0;
                                halt_pc_reg     <= '0;
                                timeout_reg     <= 1'b0;
                            end
                        endcase
                    end
                end

                S_RUN: begin
                    if (cmd_accept && (cmd_code == CMD_RESET)) begin
                        state_reg       <= S_PRST;
                        timer_reg       <= PRST_LOAD;
                        cycle_count_reg <= '0;
                        halt_pc_reg     <= '0;
                        timeout_reg     <= 1'b0;
                    end else if (halt_det || limit_hit) begin
                        // A HALT instruction wins a tie with the limit but the timeout still sticks.
                        state_reg <= S_DRAIN;
                        timer_reg <= DRAIN_LOAD;
                        if (halt_det) begin
                            halt_pc_reg <= pc_addr_in;
                        end
                        if (limit_hit) begin
                            timeout_reg <= 1'b1;
                        end
                    end else if (cmd_accept && (cmd_code == CMD_HALT)) begin
                        state_reg <= S_DRAIN;
                        timer_reg <= DRAIN_LOAD;
                    end
                end

                S_STEP: begin
                    if (halt_det) begin
                        state_reg   <= S_DRAIN;
                        timer_reg   <= DRAIN_LOAD;
                        halt_pc_reg <= pc_addr_in;
                    end else begin
                        state_reg <= S_IDLE;
                        done_reg  <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (timer_reg == '0) begin
                        state_reg <= S_HALTED;
                        done_reg  <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                S_HALTED: begin
                    if (cmd_accept && (cmd_code == CMD_RESET)) begin
                        state_reg       <= S_PRST;
                        timer_reg       <= PRST_LOAD;
                        cycle_count_reg <= '0;
                        halt_pc_reg     <= '0;
                        timeout_reg     <= 1'b0;
                    end
                end

                S_PRST: begin
                    if (timer_reg == '0) begin
                        state_reg <= S_IDLE;
                        done_reg  <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign pc_reset_out    = (state_reg == S_PRST);
    assign halted_out      = (state_reg == S_HALTED);
    assign state_out       = state_reg;
    assign cycle_count_out = cycle_count_reg;
    assign halt_pc_out     = halt_pc_reg;
    assign done_pulse      = done_reg;
    assign timeout_out     = timeout_reg;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Self-checking bench for pipeline_run_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipeline_run_ctrl;

    localparam int DRAIN   = 4;
    localparam int MAX_RUN = 10;
    localparam logic [31:0] NOP_I  = 32'h0000_0000;
    localparam logic [31:0] HALT_I = 32'hFC00_0000;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_code;
    logic        cmd_ready;
    logic [31:0] pc_instr_in;
    logic [31:0] pc_addr_in;
    logic        pc_enable_out;
    logic        pc_reset_out;
    logic [2:0]  state_out;
    logic [31:0] cycle_count_out;
    logic [31:0] halt_pc_out;
    logic        halted_out;
    logic        done_pulse;
    logic        timeout_out;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_run_ctrl #(
        .ADDR_BITS(32), .DATA_WIDTH(32), .CYCLE_CNT_BITS(32), .DRAIN_CYCLES(DRAIN),
        .HALT_OPCODE(6'b111111), .MAX_RUN_CYCLES(MAX_RUN)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(cmd_ready), .pc_instr_in(pc_instr_in), .pc_addr_in(pc_addr_in),
        .pc_enable_out(pc_enable_out), .pc_reset_out(pc_reset_out), .state_out(state_out),
        .cycle_count_out(cycle_count_out), .halt_pc_out(halt_pc_out), .halted_out(halted_out),
        .done_pulse(done_pulse), .timeout_out(timeout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_code = 2'b00; pc_instr_in = NOP_I; pc_addr_in = '0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (state_out !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", state_out); end
        n_checks++; if ({pc_enable_out, pc_reset_out, halted_out, done_pulse, timeout_out} !== 5'b0) begin
            n_errors++; $display("FAIL reset_flags: got pen=%b prst=%b halted=%b done=%b tmo=%b want all 0",
                pc_enable_out, pc_reset_out, halted_out, done_pulse, timeout_out); end
        n_checks++; if (cycle_count_out !== 32'd0 || halt_pc_out !== 32'd0) begin
            n_errors++; $display("FAIL reset_regs: got cnt=%0d hpc=%h want 0 0", cycle_count_out, halt_pc_out); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        $display("reset: state=%0d cnt=%0d", state_out, cycle_count_out);
        tick();
    endtask

    task automatic test_step();
        int highs = 0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_code = 2'b01; pc_instr_in = NOP_I; pc_addr_in = 32'(4 * i);
            @(negedge clk);
            if (pc_enable_out === 1'b1) highs++;
            n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL step_ready[%0d]: got %b want 1", i, cmd_ready); end
            tick();
            cmd_valid = 1'b0;
            @(negedge clk);
            if (pc_enable_out === 1'b1) highs++;
            n_checks++; if (state_out !== 3'd2 || pc_enable_out !== 1'b1 || done_pulse !== 1'b0) begin
                n_errors++; $display("FAIL step_active[%0d]: got st=%0d pen=%b done=%b want 2 1 0", i, state_out, pc_enable_out, done_pulse); end
            tick();
            @(negedge clk);
            if (pc_enable_out === 1'b1) highs++;
            n_checks++; if (state_out !== 3'd0 || done_pulse !== 1'b1 || pc_enable_out !== 1'b0) begin
                n_errors++; $display("FAIL step_done[%0d]: got st=%0d done=%b pen=%b want 0 1 0", i, state_out, done_pulse, pc_enable_out); end
            $display("step %0d at pc=%h: done seen 2 cycles after accept", i, pc_addr_in);
            tick();
        end
        n_checks++; if (highs != 3) begin n_errors++; $display("FAIL step_enable_highs: got %0d want 3", highs); end
        n_checks++; if (cycle_count_out !== 32'd3) begin n_errors++; $display("FAIL step_count: got %0d want 3", cycle_count_out); end
    endtask

    task automatic test_run_halt();
        cmd_valid = 1'b1; cmd_code = 2'b00; pc_instr_in = NOP_I; pc_addr_in = 32'h0C;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pc_addr_in = 32'h0C + 32'(4 * i);
            @(negedge clk);
            n_checks++; if (state_out !== 3'd1 || pc_enable_out !== 1'b1) begin
                n_errors++; $display("FAIL run_fetch[%0d]: got st=%0d pen=%b want 1 1", i, state_out, pc_enable_out); end
            tick();
        end
        pc_instr_in = HALT_I; pc_addr_in = 32'h14;
        @(negedge clk);
        n_checks++; if (pc_enable_out !== 1'b0) begin n_errors++; $display("FAIL run_halt_pen: got %b want 0", pc_enable_out); end
        tick();
        for (int d = 1; d <= DRAIN; d++) begin
            @(negedge clk);
            n_checks++; if (state_out !== 3'd3 || done_pulse !== 1'b0 || pc_enable_out !== 1'b0) begin
                n_errors++; $display("FAIL run_drain[%0d]: got st=%0d done=%b pen=%b want 3 0 0", d, state_out, done_pulse, pc_enable_out); end
            tick();
        end
        @(negedge clk);
        n_checks++; if (state_out !== 3'd4 || done_pulse !== 1'b1 || halted_out !== 1'b1) begin
            n_errors++; $display("FAIL run_halted: got st=%0d done=%b halted=%b want 4 1 1", state_out, done_pulse, halted_out); end
        n_checks++; if (halt_pc_out !== 32'h14 || cycle_count_out !== 32'd5) begin
            n_errors++; $display("FAIL run_halt_regs: got hpc=%h cnt=%0d want 14 5", halt_pc_out, cycle_count_out); end
        $display("run: halted at pc=%h after %0d fetch cycles", halt_pc_out, cycle_count_out);
        tick();
        @(negedge clk);
        n_checks++; if (done_pulse !== 1'b0 || state_out !== 3'd4) begin
            n_errors++; $display("FAIL run_done_width: got done=%b st=%0d want 0 4", done_pulse, state_out); end
    endtask

    task automatic test_halted_cmds();
        tick();
        pc_instr_in = NOP_I;
        cmd_valid = 1'b1; cmd_code = 2'b00;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL halted_ready: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (state_out !== 3'd4 || pc_enable_out !== 1'b0 || cycle_count_out !== 32'd5) begin
            n_errors++; $display("FAIL halted_run_ignored: got st=%0d pen=%b cnt=%0d want 4 0 5", state_out, pc_enable_out, cycle_count_out); end
        tick();
        cmd_valid = 1'b1; cmd_code = 2'b11;
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (pc_reset_out !== 1'b1 || state_out !== 3'd5 || cycle_count_out !== 32'd0
                        || halted_out !== 1'b0 || halt_pc_out !== 32'd0) begin
            n_errors++; $display("FAIL prst_first: got prst=%b st=%0d cnt=%0d halted=%b hpc=%h want 1 5 0 0 0",
                pc_reset_out, state_out, cycle_count_out, halted_out, halt_pc_out); end
        tick();
        @(negedge clk);
        n_checks++; if (pc_reset_out !== 1'b1 || done_pulse !== 1'b0) begin
            n_errors++; $display("FAIL prst_second: got prst=%b done=%b want 1 0", pc_reset_out, done_pulse); end
        tick();
        @(negedge clk);
        n_checks++; if (state_out !== 3'd0 || done_pulse !== 1'b1 || pc_reset_out !== 1'b0) begin
            n_errors++; $display("FAIL prst_done: got st=%0d done=%b prst=%b want 0 1 0", state_out, done_pulse, pc_reset_out); end
        $display("reset_pipe from halted: back to idle, cnt=%0d", cycle_count_out);
        tick();
    endtask

    task automatic test_run_priority();
        cmd_valid = 1'b1; cmd_code = 2'b00; pc_instr_in = NOP_I;
        tick();
        cmd_code = 2'b10; pc_instr_in = HALT_I; pc_addr_in = 32'h40;
        @(negedge clk);
        n_checks++; if (pc_enable_out !== 1'b0) begin n_errors++; $display("FAIL prio_halt_pen: got %b want 0", pc_enable_out); end
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (state_out !== 3'd3 || halt_pc_out !== 32'h40) begin
            n_errors++; $display("FAIL prio_halt_latch: got st=%0d hpc=%h want 3 40", state_out, halt_pc_out); end
        repeat (DRAIN) tick();
        cmd_valid = 1'b1; cmd_code = 2'b11;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        cmd_valid = 1'b1; cmd_code = 2'b00; pc_instr_in = NOP_I;
        @(negedge clk);
        n_checks++; if (state_out !== 3'd0) begin n_errors++; $display("FAIL prio_idle: got %0d want 0", state_out); end
        tick();
        cmd_code = 2'b11; pc_instr_in = HALT_I; pc_addr_in = 32'h80;
        @(negedge clk);
        n_checks++; if (pc_enable_out !== 1'b0 || state_out !== 3'd1) begin
            n_errors++; $display("FAIL prio_reset_pen: got pen=%b st=%0d want 0 1", pc_enable_out, state_out); end
        tick();
        cmd_valid = 1'b0; pc_instr_in = NOP_I;
        @(negedge clk);
        n_checks++; if (state_out !== 3'd5 || halt_pc_out !== 32'd0) begin
            n_errors++; $display("FAIL prio_reset_wins: got st=%0d hpc=%h want 5 0", state_out, halt_pc_out); end
        $display("priority: reset_pipe beat halt_det at pc=%h", pc_addr_in);
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_drain();
        int seen_done = 0;
        cmd_valid = 1'b1; cmd_code = 2'b00; pc_instr_in = NOP_I; pc_addr_in = 32'h20;
        tick();
        cmd_valid = 1'b0;
        tick();
        pc_instr_in = HALT_I; pc_addr_in = 32'h24;
        tick();
        @(negedge clk);
        n_checks++; if (state_out !== 3'd3 || halt_pc_out !== 32'h24 || cycle_count_out !== 32'd1) begin
            n_errors++; $display("FAIL abort_drain_entry: got st=%0d hpc=%h cnt=%0d want 3 24 1", state_out, halt_pc_out, cycle_count_out); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; pc_instr_in = NOP_I;
        @(negedge clk);
        n_checks++; if (state_out !== 3'd0 || cycle_count_out !== 32'd0 || halt_pc_out !== 32'd0
                        || {pc_enable_out, pc_reset_out, halted_out, done_pulse, timeout_out} !== 5'b0) begin
            n_errors++; $display("FAIL abort_outputs: got st=%0d cnt=%0d hpc=%h pen=%b prst=%b halted=%b done=%b tmo=%b want all 0",
                state_out, cycle_count_out, halt_pc_out, pc_enable_out, pc_reset_out, halted_out, done_pulse, timeout_out); end
        for (int i = 0; i < DRAIN + 2; i++) begin
            if (done_pulse !== 1'b0 || state_out !== 3'd0) seen_done++;
            tick();
            @(negedge clk);
        end
        n_checks++; if (seen_done != 0) begin n_errors++; $display("FAIL abort_no_done: got %0d bad cycles want 0", seen_done); end
        $display("reset in drain: aborted to idle");
        tick();
    endtask

`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    task automatic test_cycle_limit();
        int bound = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        cmd_valid = 1'b1; cmd_code = 2'b00; pc_instr_in = NOP_I;
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        while (state_out !== 3'd4 && bound < 60) begin
            bound++;
            tick();
            @(negedge clk);
        end
        n_checks++; if (state_out !== 3'd4) begin n_errors++; $display("FAIL limit_halted: got st=%0d want 4", state_out); end
        n_checks++; if (cycle_count_out !== 32'(MAX_RUN) || timeout_out !== 1'b1 || halt_pc_out !== 32'd0) begin
            n_errors++; $display("FAIL limit_regs: got cnt=%0d tmo=%b hpc=%h want %0d 1 0",
                cycle_count_out, timeout_out, halt_pc_out, MAX_RUN); end
        $display("cycle limit: stopped at cnt=%0d", cycle_count_out);
        tick();
    endtask
`endif

    // Reference model: spec-level phases with "cycles remaining" counters.
    task automatic test_random();
        int          m_st, m_left;
        logic [31:0] m_cnt, m_hpc;
        logic        m_tmo, m_done;
        logic        e_ready, e_pen, acc, hd, lim, go_prst;
        logic [2:0]  e_st;
        reset = 1'b1; cmd_valid = 1'b0; tick(); tick(); reset = 1'b0;
        m_st = 0; m_left = 0; m_cnt = 0; m_hpc = 0; m_tmo = 0; m_done = 0;
        for (int c = 0; c < 600; c++) begin
            reset       = ($urandom_range(0, 99) == 0);
            cmd_valid   = ($urandom_range(0, 9) < 4);
            cmd_code    = 2'($urandom_range(0, 3));
            pc_addr_in  = $urandom & 32'hFFFF_FFFC;
            pc_instr_in = ($urandom_range(0, 9) == 0) ? HALT_I : {6'($urandom_range(0, 62)), 26'($urandom)};
            @(negedge clk);
            hd      = (pc_instr_in[31:26] == 6'h3F);
            e_ready = (m_st == 0) || (m_st == 1) || (m_st == 4);
            acc     = cmd_valid && e_ready;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
            lim = (m_st == 1) && (m_cnt >= 32'(MAX_RUN));
`else
            lim = 1'b0;
`endif
            e_pen = ((m_st == 1) && !hd && !lim && !(acc && cmd_code[1])) || ((m_st == 2) && !hd);
            e_st  = 3'(m_st);
            n_checks++; if ({state_out, cmd_ready, pc_enable_out, pc_reset_out, halted_out, done_pulse, timeout_out}
                            !== {e_st, e_ready, e_pen, (m_st == 5), (m_st == 4), m_done, m_tmo}) begin
                n_errors++; $display("FAIL rand_ctrl[%0d]: got st=%0d rdy=%b pen=%b prst=%b hlt=%b done=%b tmo=%b want %0d %b %b %b %b %b %b",
                    c, state_out, cmd_ready, pc_enable_out, pc_reset_out, halted_out, done_pulse, timeout_out,
                    e_st, e_ready, e_pen, (m_st == 5), (m_st == 4), m_done, m_tmo); end
            n_checks++; if (cycle_count_out !== m_cnt || halt_pc_out !== m_hpc) begin
                n_errors++; $display("FAIL rand_regs[%0d]: got cnt=%0d hpc=%h want %0d %h", c, cycle_count_out, halt_pc_out, m_cnt, m_hpc); end
            if (reset) $display("rand %0d: reset", c);
            else if (acc) $display("rand %0d: cmd %0d accepted in state %0d", c, cmd_code, m_st);
            if (reset) begin
                m_st = 0; m_left = 0; m_cnt = 0; m_hpc = 0; m_tmo = 0; m_done = 0;
            end else begin
                m_done  = 1'b0;
                go_prst = 1'b0;
                if (e_pen && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                case (m_st)
                    0: if (acc) begin
                        if (cmd_code == 2'd0) m_st = 1;
                        else if (cmd_code == 2'd1) m_st = 2;
                        else if (cmd_code == 2'd2) begin m_st = 3; m_left = DRAIN; end
                        else go_prst = 1'b1;
                    end
                    1: if (acc && cmd_code == 2'd3) go_prst = 1'b1;
                       else if (hd || lim) begin
                           m_st = 3; m_left = DRAIN;
                           if (hd) m_hpc = pc_addr_in;
                           if (lim) m_tmo = 1'b1;
                       end else if (acc && cmd_code == 2'd2) begin m_st = 3; m_left = DRAIN; end
                    2: if (hd) begin m_st = 3; m_left = DRAIN; m_hpc = pc_addr_in; end
                       else begin m_st = 0; m_done = 1'b1; end
                    3: begin m_left--; if (m_left == 0) begin m_st = 4; m_done = 1'b1; end end
                    4: if (acc && cmd_code == 2'd3) go_prst = 1'b1;
                    default: begin m_left--; if (m_left == 0) begin m_st = 0; m_done = 1'b1; end end
                endcase
                if (go_prst) begin
                    m_st = 5; m_left = 2; m_cnt = 0; m_hpc = 0; m_tmo = 1'b0;
                end
            end
            tick();
        end
        reset = 1'b0; cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_step();
        test_run_halt();
        test_halted_cmds();
        test_run_priority();
        test_reset_mid_drain();
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
        test_cycle_limit();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
